shift_add_mult16: RTL and testbench



---
 rtl/shift_add_mult16_pkg.sv | 21 ++
 rtl/shift_add_mult16_if.sv | 26 ++
 rtl/shift_add_mult16_cla_add16.sv | 44 ++++
 rtl/shift_add_mult16.sv | 91 +++++++++
 tb/tb_shift_add_mult16.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/shift_add_mult16_pkg.sv
// mult_pkg: shared types and constants for the shift-and-add multiplier.
//   state_t      : FSM encoding {IDLE, RUN, DONE}
//   WIDTH_DEF    : default operand width
//   CNT_W        : step counter width for the default operand width
//   cnt_width()  : step counter width for any operand width
package mult_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/shift_add_mult16_if.sv
// shift_add_mult16_if: operand and result handshakes of the multiplier.
//   start_valid/start_ready/a/b : operand request (master -> slave)
//   res_valid/res_ready/product : result response (slave -> master)
//   modport master : the producer/consumer around the multiplier
//   modport slave  : the multiplier itself
interface shift_add_mult16_if #(
  parameter int WIDTH = mult_pkg::WIDTH_DEF
);
  logic               start_valid;
  logic               start_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, product
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, product
  );
endinterface

// File: rtl/shift_add_mult16_cla_add16.sv
// cla_add16: combinational adder made of 4-bit carry-lookahead slices.
// Carries ripple between slices; inside a slice every carry is a direct
// sum-of-products of generate/propagate terms.
//   i_a, i_b : addends (WIDTH bits, WIDTH a multiple of 4)
//   i_cin    : carry in
//   o_s      : sum
//   o_cout   : carry out
module cla_add16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout
);
  localparam int NSL = WIDTH / 4;

  logic [NSL:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gs = 0; gs < NSL; gs++) begin : g_slice
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_cc;

    assign w_g     = i_a[gs*4 +: 4] & i_b[gs*4 +: 4];
    assign w_p     = i_a[gs*4 +: 4] ^ i_b[gs*4 +: 4];
    assign w_cc[0] = w_c[gs];
    assign w_cc[1] = w_g[0] | (w_p[0] & w_cc[0]);
    assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cc[0]);

    assign o_s[gs*4 +: 4] = w_p ^ w_cc[3:0];
    assign w_c[gs+1]      = w_cc[4];
  end

  assign o_cout = w_c[NSL];
endmodule

// File: rtl/shift_add_mult16.sv
// shift_add_mult16: sequential unsigned WIDTHxWIDTH shift-and-add multiplier.
// One adder step per clock, fixed latency of WIDTH steps after the accept edge.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation
//   bus   : slave side of shift_add_mult16_if (operand and result handshakes)
module shift_add_mult16
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_add_mult16_if.slave   bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;

  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  // Multiplier LSB selects whether this step adds the multiplicand.
  assign w_addend = r_q[0] ? r_mcand : '0;

  cla_add16 #(.WIDTH(WIDTH)) u_add (
    .i_a    (r_acc_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_valid) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = DONE;
      end
      DONE: begin
        // Returning to IDLE never accepts on the same edge.
        if (bus.res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_mcand  <= bus.a;
        r_q      <= bus.b;
        r_acc_hi <= '0;
        r_cnt    <= '0;
      end else if (w_step) begin
        // Carry-out shifts into the top of acc_hi, so the step never overflows;
        // the sum LSB moves into the vacated top of q.
        r_acc_hi <= {w_cout, w_sum[WIDTH-1:1]};
        r_q      <= {w_sum[0], r_q[WIDTH-1:1]};
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.start_ready = (r_state == IDLE);
  assign bus.res_valid   = (r_state == DONE);
  assign bus.product     = {r_acc_hi, r_q};
endmodule

// File: tb/tb_shift_add_mult16.sv
// tb_shift_add_mult16: directed vector table, handshake corner sequences,
// asynchronous reset abort and a random sweep for shift_add_mult16.
module tb_shift_add_mult16;
  import mult_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_add_mult16_if #(.WIDTH(16)) bus ();

  shift_add_mult16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          stall;
    logic [31:0] exp;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Wait for IDLE, issue one operation, scramble a/b during RUN, wait for the
  // result, hold res_ready low for 'stall' cycles, then complete the handshake.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int stall,
                       output logic [31:0] prod, output logic [31:0] lat,
                       output logic [31:0] held);
    int w;
    w = 0;
    while (!bus.start_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    bus.a = a; bus.b = b; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.a = 16'hDEAD; bus.b = 16'hBEEF;
    lat = 0;
    while (!bus.res_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    prod = bus.product;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    held = bus.product;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] prod, lat, held;
    logic [15:0] ra, rb;

    vecs[0] = '{16'h1234, 16'h5678, 0, 32'h0626_0060};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 0, 32'hFFFE_0001};
    vecs[2] = '{16'h0000, 16'hABCD, 1, 32'h0000_0000};
    vecs[3] = '{16'h00FF, 16'h0101, 0, 32'h0000_FFFF};
    vecs[4] = '{16'h0001, 16'h0001, 2, 32'h0000_0001};
    vecs[5] = '{16'hFFFF, 16'h0001, 0, 32'h0000_FFFF};
    vecs[6] = '{16'h8000, 16'h0002, 3, 32'h0001_0000};
    vecs[7] = '{16'h8000, 16'h8000, 0, 32'h4000_0000};

    bus.start_valid = 1'b0; bus.res_ready = 1'b0;
    bus.a = '0; bus.b = '0;

    #2;
    chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
    chk("rst_res_valid",   32'(bus.res_valid),   32'd0);
    chk("rst_product",     bus.product,          32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].stall, prod, lat, held);
      chk($sformatf("vec%0d_product", i), prod, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 32'd16);
      chk($sformatf("vec%0d_held", i), held, vecs[i].exp);
    end

    // Backpressure: result held, new start ignored.
    bus.a = 16'h00FF; bus.b = 16'h0101; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_latency", lat, 32'd16);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.a = 16'h0001; bus.b = 16'h0001; bus.start_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      chk($sformatf("bp%0d_product", i), bus.product, 32'h0000_FFFF);
      chk($sformatf("bp%0d_res_valid", i), 32'(bus.res_valid), 32'd1);
      chk($sformatf("bp%0d_start_ready", i), 32'(bus.start_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("bp_release_res_valid",   32'(bus.res_valid),   32'd0);
    chk("bp_release_start_ready", 32'(bus.start_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_no_queued_start", 32'(bus.start_ready), 32'd1);

    // Back-to-back with res_ready tied high and start_valid held.
    bus.res_ready = 1'b1;
    bus.a = 16'h0003; bus.b = 16'h0005; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'h0007; bus.b = 16'h0009;
    chk("b2b_busy", 32'(bus.start_ready), 32'd0);
    lat = 0;
    while (!bus.res_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("b2b_first_latency", lat, 32'd16);
    chk("b2b_first_product", bus.product, 32'h0000_000F);
    @(posedge clk); #1;
    chk("b2b_gap_start_ready", 32'(bus.start_ready), 32'd1);
    chk("b2b_gap_res_valid",   32'(bus.res_valid),   32'd0);
    @(posedge clk); #1;
    chk("b2b_second_accept", 32'(bus.start_ready), 32'd0);
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("b2b_second_latency", lat, 32'd16);
    chk("b2b_second_product", bus.product, 32'h0000_003F);
    @(posedge clk); #1;
    bus.res_ready = 1'b0;

    // Asynchronous reset in the middle of step 8.
    bus.a = 16'hFFFF; bus.b = 16'h0002; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    chk("rst_mid_running", 32'(bus.start_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_res_valid",   32'(bus.res_valid),   32'd0);
    chk("rst_mid_product",     bus.product,          32'd0);
    chk("rst_mid_start_ready", 32'(bus.start_ready), 32'd1);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0002, 16'h0003, 0, prod, lat, held);
    chk("post_rst_product", prod, 32'h0000_0006);
    chk("post_rst_latency", lat, 32'd16);

    // Random sweep with random result stalls.
    for (int i = 0; i < 1500; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 3)), prod, lat, held);
      chk($sformatf("rnd%0d_%h_x_%h", i, ra, rb), prod, 32'(ra) * 32'(rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
